alu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the shared bus-based ALU datapath for register-register logic instructions (AND, OR, NEG, NOT).
Accepts one operation per start/done handshake and drives the datapath control strobes:
- bus source select
- Y-register load
- one-hot ALU op selects
- Z-register load
- Z-low bus drive
- destination register write
It sits between the instruction decode/control unit and the datapath. It also keeps a saturating count of completed operations for debug.

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control sequencer for the shared-bus ALU datapath. It steps AND/OR/NEG/NOT through
// operand load, execute and write-back, and keeps a saturating count of completed operations.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       bus_sel,
    output logic             y_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             r_in,
    output logic             and_sel,
    output logic             or_sel,
    output logic             neg_sel,
    output logic             not_sel,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        EXEC   = 3'd2,
        WRITE  = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NEG = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_RB   = 2'd1;
    localparam logic [1:0] BUS_RC   = 2'd2;

    state_t           state_q;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt_q;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == IDLE && start)
                op_q <= opcode;
            if (state_q == WRITE && !stall)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    // Stall never applies in IDLE, so a start is accepted even while stall is high.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_AND, OP_OR:  state_nxt = LOAD_Y;
                        OP_NEG, OP_NOT: state_nxt = EXEC;
                        default:        state_nxt = ERR;
                    endcase
                end
            end
            LOAD_Y: if (!stall) state_nxt = EXEC;
            EXEC:   if (!stall) state_nxt = WRITE;
            WRITE:  if (!stall) state_nxt = IDLE;
            ERR:    if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Op selects follow the latched opcode through a stall; every other strobe is gated off.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = 1'b0;
        err     = 1'b0;
        bus_sel = BUS_NONE;
        y_in    = 1'b0;
        z_in    = 1'b0;
        zlo_out = 1'b0;
        r_in    = 1'b0;
        and_sel = 1'b0;
        or_sel  = 1'b0;
        neg_sel = 1'b0;
        not_sel = 1'b0;
        case (state_q)
            LOAD_Y: begin
                if (!stall) begin
                    bus_sel = BUS_RB;
                    y_in    = 1'b1;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_AND:  and_sel = 1'b1;
                    OP_OR:   or_sel  = 1'b1;
                    OP_NEG:  neg_sel = 1'b1;
                    OP_NOT:  not_sel = 1'b1;
                    default: ;
                endcase
                if (!stall) begin
                    z_in    = 1'b1;
                    bus_sel = (op_q == OP_AND || op_q == OP_OR) ? BUS_RC : BUS_RB;
                end
            end
            WRITE: begin
                if (!stall) begin
                    zlo_out = 1'b1;
                    r_in    = 1'b1;
                    done    = 1'b1;
                end
            end
            ERR: begin
                if (!stall) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: each cycle's expected outputs are queued ahead of
// the stimulus and popped for comparison while the DUT holds that cycle's state.
module tb_alu_sequencer;

    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       opcode;
    logic             stall;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       bus_sel;
    logic             y_in;
    logic             z_in;
    logic             zlo_out;
    logic             r_in;
    logic             and_sel;
    logic             or_sel;
    logic             neg_sel;
    logic             not_sel;
    logic [CNT_W-1:0] op_count;

    // {busy,done,err,bus_sel,y_in,z_in,zlo_out,r_in,and,or,neg,not,op_count}
    typedef logic [14:0] outvec_t;

    outvec_t exp_q[$];
    string   tag_q[$];
    int      errors = 0;
    int      checks = 0;

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .stall(stall),
        .busy(busy), .done(done), .err(err), .bus_sel(bus_sel), .y_in(y_in),
        .z_in(z_in), .zlo_out(zlo_out), .r_in(r_in), .and_sel(and_sel),
        .or_sel(or_sel), .neg_sel(neg_sel), .not_sel(not_sel), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel is {and,or,neg,not}
    task automatic ex(input string tag, input logic bsy, input logic dn, input logic er,
                      input logic [1:0] bs, input logic yi, input logic zi, input logic zl,
                      input logic ri, input logic [3:0] sel, input logic [1:0] cnt);
        exp_q.push_back({bsy, dn, er, bs, yi, zi, zl, ri, sel, cnt});
        tag_q.push_back(tag);
    endtask

    task automatic idle_ex(input string tag, input logic [1:0] cnt);
        ex(tag, 0, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, cnt);
    endtask

    // Drives one cycle of inputs, compares mid-cycle, then advances past the next edge.
    task automatic cyc(input logic st, input logic [3:0] op, input logic stl);
        outvec_t obs;
        outvec_t expv;
        string   tag;
        start  = st;
        opcode = op;
        stall  = stl;
        @(negedge clk);
        obs = {busy, done, err, bus_sel, y_in, z_in, zlo_out, r_in,
               and_sel, or_sel, neg_sel, not_sel, op_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%b required=<queued entry>", obs);
        end else begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s observed=%b required=%b", tag, obs, expv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 4'd0;
        stall  = 1'b0;
        @(posedge clk);
        #1;
        idle_ex("reset_state", 2'd0);
        cyc(0, 4'd0, 0);
        reset = 1'b0;

        // AND: LOAD_Y, EXEC, WRITE
        idle_ex("and_idle", 2'd0);                             cyc(1, 4'd0, 0);
        ex("and_load_y", 1, 0, 0, 2'd1, 1, 0, 0, 0, 4'b0000, 2'd0); cyc(0, 4'd0, 0);
        ex("and_exec",   1, 0, 0, 2'd2, 0, 1, 0, 0, 4'b1000, 2'd0); cyc(0, 4'd0, 0);
        ex("and_write",  1, 1, 0, 2'd0, 0, 0, 1, 1, 4'b0000, 2'd0); cyc(0, 4'd0, 0);

        // NOT skips LOAD_Y; one stalled WRITE cycle delays done and the count
        idle_ex("not_idle_cnt1", 2'd1);                        cyc(1, 4'd3, 0);
        ex("not_exec",   1, 0, 0, 2'd1, 0, 1, 0, 0, 4'b0001, 2'd1); cyc(0, 4'd0, 0);
        ex("not_write_stalled", 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, 2'd1); cyc(0, 4'd0, 1);
        ex("not_write",  1, 1, 0, 2'd0, 0, 0, 1, 1, 4'b0000, 2'd1); cyc(0, 4'd0, 0);

        // Illegal opcode back-to-back, accepted while stall is high
        idle_ex("ill_idle_cnt2", 2'd2);                        cyc(1, 4'd9, 1);
        ex("ill_err_stalled", 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, 2'd2); cyc(0, 4'd0, 1);
        ex("ill_err",    1, 1, 1, 2'd0, 0, 0, 0, 0, 4'b0000, 2'd2); cyc(0, 4'd0, 0);

        // OR with a 3-cycle stall in EXEC
        idle_ex("or_idle_cnt2", 2'd2);                         cyc(1, 4'd1, 0);
        ex("or_load_y",  1, 0, 0, 2'd1, 1, 0, 0, 0, 4'b0000, 2'd2); cyc(0, 4'd0, 0);
        for (int i = 0; i < 3; i++) begin
            ex($sformatf("or_exec_stall%0d", i), 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0100, 2'd2);
            cyc(0, 4'd0, 1);
        end
        ex("or_exec",    1, 0, 0, 2'd2, 0, 1, 0, 0, 4'b0100, 2'd2); cyc(0, 4'd0, 0);
        ex("or_write",   1, 1, 0, 2'd0, 0, 0, 1, 1, 4'b0000, 2'd2); cyc(0, 4'd0, 0);

        // NEG with extra starts and opcode changes while busy
        idle_ex("neg_idle_cnt3", 2'd3);                        cyc(1, 4'd2, 0);
        ex("neg_exec_ignore_start", 1, 0, 0, 2'd1, 0, 1, 0, 0, 4'b0010, 2'd3); cyc(1, 4'd0, 0);
        ex("neg_write_ignore_start", 1, 1, 0, 2'd0, 0, 0, 1, 1, 4'b0000, 2'd3); cyc(1, 4'd9, 0);
        idle_ex("neg_no_requeue", 2'd3);                       cyc(0, 4'd0, 0);

        // Fifth completion leaves the counter saturated
        idle_ex("sat_idle", 2'd3);                             cyc(1, 4'd3, 0);
        ex("sat_exec",   1, 0, 0, 2'd1, 0, 1, 0, 0, 4'b0001, 2'd3); cyc(0, 4'd0, 0);
        ex("sat_write",  1, 1, 0, 2'd0, 0, 0, 1, 1, 4'b0000, 2'd3); cyc(0, 4'd0, 0);
        idle_ex("sat_hold", 2'd3);                             cyc(0, 4'd0, 0);

        // Reset during EXEC of an AND abandons it without done
        idle_ex("rst_idle", 2'd3);                             cyc(1, 4'd0, 0);
        ex("rst_load_y", 1, 0, 0, 2'd1, 1, 0, 0, 0, 4'b0000, 2'd3); cyc(0, 4'd0, 0);
        reset = 1'b1;
        ex("rst_exec",   1, 0, 0, 2'd2, 0, 1, 0, 0, 4'b1000, 2'd3); cyc(0, 4'd0, 0);
        reset = 1'b0;
        idle_ex("rst_after", 2'd0);                            cyc(0, 4'd0, 0);
        idle_ex("rst_no_done", 2'd0);                          cyc(0, 4'd0, 0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
